sram_responder: RTL and testbench

Memory-side responder for the core's `inst_sram_*` and `data_sram_*` request ports. It has two ports. Each port takes requests of the form en/wen/addr/wdata and returns rdata one cycle later, which is what the core's IF and MEM stages expect. The block translates kseg0/kseg1 virtual addresses, serves a shared word-addressed RAM, and decodes a small MMIO window (LED, timer, switches). It sits beside `mycpu_core` in the SoC top and is the test-bench memory for functional simulation.

---
 rtl/sram_responder.sv | 174 +++++++++++++++++
 tb/tb_sram_responder.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
// sram_responder: two-port (instruction/data) memory responder.
// Translates kseg0/kseg1 virtual addresses, serves a shared word-addressed
// RAM and decodes a small MMIO window (LED, TIMER, SWITCH). Both ports
// return registered read data one cycle after the request edge.
module sram_responder #(
    parameter int unsigned ADDR_W    = 14,
    parameter string       INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [15:0] switch_in,
    output logic [15:0] led_out,
    output logic        err,
    output logic [31:0] err_addr
);

    localparam int unsigned WORDS      = 1 << ADDR_W;
    localparam logic [15:0] MMIO_SEG   = 16'h1faf;
    localparam logic [15:0] OFF_LED    = 16'hf000;
    localparam logic [15:0] OFF_TIMER  = 16'hf004;
    localparam logic [15:0] OFF_SWITCH = 16'hf008;

    logic [31:0] mem [WORDS];

    // kseg0/kseg1 map onto the low 512 MB; every other segment is unmapped 1:1.
    function automatic logic [31:0] xlate(input logic [31:0] va);
        logic [31:0] pa;
        pa = va;
        if (va[31:29] == 3'b100 || va[31:29] == 3'b101) pa[31:29] = 3'b000;
        return pa;
    endfunction

    logic [31:0]       inst_pa, data_pa;
    logic              inst_ram, data_ram, data_mmio;
    logic [ADDR_W-1:0] inst_idx, data_idx;
    logic [15:0]       data_off;

    logic [31:0] inst_rdata_d, inst_rdata_q;
    logic [31:0] data_rdata_d, data_rdata_q;
    logic [15:0] led_d, led_q;
    logic [31:0] timer_d, timer_q;
    logic        err_d, err_q;
    logic [31:0] err_addr_d, err_addr_q;
    logic        ram_we;
    logic        inst_fault, data_fault;

    logic unused_ok;
    assign unused_ok = ^{inst_sram_wdata, inst_pa[1:0], data_pa[1:0]};

    // Address translation and region decode for both ports.
    always_comb begin
        inst_pa   = xlate(inst_sram_addr);
        data_pa   = xlate(data_sram_addr);
        inst_ram  = (inst_pa[31:ADDR_W+2] == '0);
        data_ram  = (data_pa[31:ADDR_W+2] == '0);
        data_mmio = (data_pa[31:16] == MMIO_SEG);
        inst_idx  = inst_pa[ADDR_W+1:2];
        data_idx  = data_pa[ADDR_W+1:2];
        data_off  = {data_pa[15:2], 2'b00};
    end

    // Next-state for read data, MMIO registers, RAM write strobe and error capture.
    always_comb begin
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        led_d        = led_q;
        timer_d      = timer_q + 32'd1;
        err_d        = err_q;
        err_addr_d   = err_addr_q;
        ram_we       = 1'b0;
        inst_fault   = 1'b0;
        data_fault   = 1'b0;

        if (inst_sram_en && inst_sram_wen == '0) begin
            if (inst_ram) begin
                inst_rdata_d = mem[inst_idx];
            end else begin
                inst_rdata_d = '0;
                inst_fault   = 1'b1;
            end
        end

        if (data_sram_en) begin
            if (data_sram_wen == '0) begin
                if (data_ram) begin
                    data_rdata_d = mem[data_idx];
                end else if (data_mmio) begin
                    case (data_off)
                        OFF_LED:    data_rdata_d = {16'h0000, led_q};
                        OFF_TIMER:  data_rdata_d = timer_q;
                        OFF_SWITCH: data_rdata_d = {16'h0000, switch_in};
                        default:    data_rdata_d = '0;
                    endcase
                end else begin
                    data_rdata_d = '0;
                    data_fault   = 1'b1;
                end
            end else begin
                if (data_ram) begin
                    ram_we = rst;
                end else if (data_mmio) begin
                    if (data_off == OFF_LED) begin
                        if (data_sram_wen[0]) led_d[7:0]  = data_sram_wdata[7:0];
                        if (data_sram_wen[1]) led_d[15:8] = data_sram_wdata[15:8];
                    end else if (data_off == OFF_TIMER) begin
                        // A written cycle merges lanes over the current value and skips the increment.
                        timer_d = timer_q;
                        for (int unsigned i = 0; i < 4; i++) begin
                            if (data_sram_wen[i]) timer_d[8*i +: 8] = data_sram_wdata[8*i +: 8];
                        end
                    end
                end else begin
                    data_fault = 1'b1;
                end
            end
        end

        // When both ports fault in the same cycle the instruction address is recorded.
        if (!err_q) begin
            if (inst_fault) begin
                err_d      = 1'b1;
                err_addr_d = inst_sram_addr;
            end else if (data_fault) begin
                err_d      = 1'b1;
                err_addr_d = data_sram_addr;
            end
        end
    end

    // Register state with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            led_q        <= '0;
            timer_q      <= '0;
            err_q        <= 1'b0;
            err_addr_q   <= '0;
        end else begin
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            led_q        <= led_d;
            timer_q      <= timer_d;
            err_q        <= err_d;
            err_addr_q   <= err_addr_d;
        end
    end

    // RAM byte-lane writes; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (data_sram_wen[i]) mem[data_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
        end
    end

    assign inst_sram_rdata = inst_rdata_q;
    assign data_sram_rdata = data_rdata_q;
    assign led_out         = led_q;
    assign err             = err_q;
    assign err_addr        = err_addr_q;

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: directed scenarios plus a
// randomized run checked against a byte-level behavioural model.
module tb_sram_responder;

    localparam int unsigned ADDR_W = 14;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_sram_en = 1'b0;
    logic [3:0]  inst_sram_wen = '0;
    logic [31:0] inst_sram_addr = '0;
    logic [31:0] inst_sram_wdata = '0;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_en = 1'b0;
    logic [3:0]  data_sram_wen = '0;
    logic [31:0] data_sram_addr = '0;
    logic [31:0] data_sram_wdata = '0;
    logic [31:0] data_sram_rdata;
    logic [15:0] switch_in = '0;
    logic [15:0] led_out;
    logic        err;
    logic [31:0] err_addr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sram_responder #(.ADDR_W(ADDR_W), .INIT_FILE("")) dut (
        .clk(clk), .rst(rst),
        .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata),
        .switch_in(switch_in), .led_out(led_out), .err(err), .err_addr(err_addr)
    );

    // ---------------- behavioural model ----------------
    logic [7:0]  m_bytes [int unsigned];
    logic [31:0] m_irdata, m_drdata, m_timer, m_err_addr;
    logic [15:0] m_led;
    logic        m_err;

    function automatic logic [31:0] m_xlate(input logic [31:0] va);
        if (va >= 32'h8000_0000 && va < 32'hA000_0000) return va - 32'h8000_0000;
        if (va >= 32'hA000_0000 && va < 32'hC000_0000) return va - 32'hA000_0000;
        return va;
    endfunction

    function automatic bit m_is_ram(input logic [31:0] pa);
        return pa < (32'd1 << (ADDR_W + 2));
    endfunction

    function automatic bit m_is_mmio(input logic [31:0] pa);
        return (pa / 32'h1_0000) == 32'h1faf;
    endfunction

    function automatic logic [31:0] m_word(input logic [31:0] pa);
        logic [31:0] base, w;
        base = pa - (pa % 4);
        for (int i = 0; i < 4; i++)
            w[8*i +: 8] = m_bytes.exists(base + i) ? m_bytes[base + i] : 8'hxx;
        return w;
    endfunction

    task automatic model_reset();
        m_irdata = 0; m_drdata = 0; m_timer = 0; m_err_addr = 0; m_led = 0; m_err = 0;
    endtask

    // One rising edge: reads see pre-edge state, then writes and the timer update.
    task automatic model_step();
        logic [31:0] ipa, dpa, base, next_timer;
        logic [15:0] off;
        bit ifault, dfault;
        ifault = 0; dfault = 0;
        next_timer = m_timer + 1;
        if (inst_sram_en && inst_sram_wen == 0) begin
            ipa = m_xlate(inst_sram_addr);
            if (m_is_ram(ipa)) m_irdata = m_word(ipa);
            else begin m_irdata = 0; ifault = 1; end
        end
        if (data_sram_en) begin
            dpa = m_xlate(data_sram_addr);
            off = dpa[15:0] & 16'hfffc;
            if (data_sram_wen == 0) begin
                if (m_is_ram(dpa)) m_drdata = m_word(dpa);
                else if (m_is_mmio(dpa)) begin
                    if (off == 16'hf000) m_drdata = {16'h0, m_led};
                    else if (off == 16'hf004) m_drdata = m_timer;
                    else if (off == 16'hf008) m_drdata = {16'h0, switch_in};
                    else m_drdata = 0;
                end else begin m_drdata = 0; dfault = 1; end
            end else begin
                if (m_is_ram(dpa)) begin
                    base = dpa - (dpa % 4);
                    for (int i = 0; i < 4; i++)
                        if (data_sram_wen[i]) m_bytes[base + i] = data_sram_wdata[8*i +: 8];
                end else if (m_is_mmio(dpa)) begin
                    if (off == 16'hf000) begin
                        for (int i = 0; i < 2; i++)
                            if (data_sram_wen[i]) m_led[8*i +: 8] = data_sram_wdata[8*i +: 8];
                    end else if (off == 16'hf004) begin
                        next_timer = m_timer;
                        for (int i = 0; i < 4; i++)
                            if (data_sram_wen[i]) next_timer[8*i +: 8] = data_sram_wdata[8*i +: 8];
                    end
                end else dfault = 1;
            end
        end
        m_timer = next_timer;
        if (!m_err && (ifault || dfault)) begin
            m_err = 1;
            m_err_addr = ifault ? inst_sram_addr : data_sram_addr;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        inst_sram_en = 0; inst_sram_wen = 0;
        data_sram_en = 0; data_sram_wen = 0;
    endtask

    task automatic inst_rd(input logic [31:0] a);
        inst_sram_en = 1; inst_sram_wen = 0; inst_sram_addr = a;
    endtask

    task automatic data_rd(input logic [31:0] a);
        data_sram_en = 1; data_sram_wen = 0; data_sram_addr = a;
    endtask

    task automatic data_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        data_sram_en = 1; data_sram_wen = w; data_sram_addr = a; data_sram_wdata = d;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle();
        rst = 0;
        repeat (2) begin @(posedge clk); #1; end
        total++;
        if ({inst_sram_rdata, data_sram_rdata, led_out, err, err_addr} !== '0) begin
            bad++;
            $display("FAIL reset_state got irdata=%h drdata=%h led=%h err=%b err_addr=%h exp all zero",
                     inst_sram_rdata, data_sram_rdata, led_out, err, err_addr);
        end
        model_reset();
        rst = 1;
    endtask

    task automatic test_fetch();
        data_wr(32'h8000_0000, 32'h3C08_BFAF, 4'hF); tick(); idle();
        inst_sram_en = 1; inst_sram_wen = 4'hF; inst_sram_addr = 32'h4000_0000; tick(); idle();
        total++;
        if (err !== 1'b0 || inst_sram_rdata !== 32'h0) begin
            bad++;
            $display("FAIL inst_wen_ignored got err=%b rdata=%h exp err=0 rdata=0", err, inst_sram_rdata);
        end
        inst_rd(32'hBFC0_0000); tick(); idle();
        total++;
        if (inst_sram_rdata !== 32'h0 || err !== 1'b1 || err_addr !== 32'hBFC0_0000) begin
            bad++;
            $display("FAIL fetch_unmapped got rdata=%h err=%b err_addr=%h exp 0/1/bfc00000",
                     inst_sram_rdata, err, err_addr);
        end
        inst_rd(32'h8000_0000); tick(); idle();
        total++;
        if (inst_sram_rdata !== 32'h3C08_BFAF) begin
            bad++;
            $display("FAIL fetch_kseg0 got=%h exp=3c08bfaf", inst_sram_rdata);
        end
        tick();
        total++;
        if (inst_sram_rdata !== 32'h3C08_BFAF) begin
            bad++;
            $display("FAIL fetch_hold got=%h exp=3c08bfaf", inst_sram_rdata);
        end
    endtask

    task automatic test_byte_writes();
        data_rd(32'hA000_0000); tick();
        data_wr(32'h8000_0010, 32'hAABB_CCDD, 4'b1111); tick();
        data_wr(32'h8000_0010, 32'h1122_3344, 4'b0101); tick(); idle();
        total++;
        if (data_sram_rdata !== 32'h3C08_BFAF) begin
            bad++;
            $display("FAIL write_holds_rdata got=%h exp=3c08bfaf", data_sram_rdata);
        end
        data_rd(32'h8000_0010); tick(); idle();
        total++;
        if (data_sram_rdata !== 32'hAA22_CC44) begin
            bad++;
            $display("FAIL byte_merge got=%h exp=aa22cc44", data_sram_rdata);
        end
    endtask

    task automatic test_conflict();
        data_wr(32'h8000_0020, 32'h0, 4'hF); tick();
        data_wr(32'h8000_0020, 32'hFFFF_FFFF, 4'hF); inst_rd(32'h8000_0020); tick(); idle();
        total++;
        if (inst_sram_rdata !== 32'h0) begin
            bad++;
            $display("FAIL conflict_old_data got=%h exp=00000000", inst_sram_rdata);
        end
        data_rd(32'h8000_0020); inst_rd(32'hA000_0020); tick(); idle();
        total++;
        if (data_sram_rdata !== 32'hFFFF_FFFF || inst_sram_rdata !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL conflict_commit got d=%h i=%h exp ffffffff", data_sram_rdata, inst_sram_rdata);
        end
    endtask

    task automatic test_boundary();
        data_wr(32'h8000_FFFC, 32'h5A5A_1234, 4'hF); tick(); idle();
        inst_rd(32'hA000_FFFF); tick(); idle();
        total++;
        if (inst_sram_rdata !== 32'h5A5A_1234) begin
            bad++;
            $display("FAIL last_word got=%h exp=5a5a1234", inst_sram_rdata);
        end
        data_rd(32'h8001_0000); tick(); idle();
        total++;
        if (data_sram_rdata !== 32'h0 || err !== 1'b1 || err_addr !== 32'hBFC0_0000) begin
            bad++;
            $display("FAIL past_ram_end got rdata=%h err=%b err_addr=%h exp 0/1/bfc00000",
                     data_sram_rdata, err, err_addr);
        end
    endtask

    task automatic test_mmio();
        switch_in = 16'h00F0;
        data_wr(32'hBFAF_F000, 32'h0000_ABCD, 4'hF); tick();
        data_wr(32'hBFAF_F000, 32'hFFFF_0000, 4'b1100); tick(); idle();
        total++;
        if (led_out !== 16'hABCD) begin
            bad++;
            $display("FAIL led_write got=%h exp=abcd", led_out);
        end
        data_rd(32'hBFAF_F000); tick();
        total++;
        if (data_sram_rdata !== 32'h0000_ABCD) begin
            bad++;
            $display("FAIL led_read got=%h exp=0000abcd", data_sram_rdata);
        end
        data_wr(32'hBFAF_F008, 32'h1234_5678, 4'hF); tick();
        data_rd(32'hBFAF_F008); tick(); idle();
        total++;
        if (data_sram_rdata !== 32'h0000_00F0) begin
            bad++;
            $display("FAIL switch_read got=%h exp=000000f0", data_sram_rdata);
        end
        data_rd(32'hBFAF_F00C); tick(); idle();
        total++;
        if (data_sram_rdata !== 32'h0 || err_addr !== 32'hBFC0_0000) begin
            bad++;
            $display("FAIL mmio_hole got rdata=%h err_addr=%h exp 0/bfc00000", data_sram_rdata, err_addr);
        end
        data_wr(32'hBFAF_F004, 32'h0000_0100, 4'hF); tick(); idle();
        tick(); tick();
        data_rd(32'hBFAF_F004); tick(); idle();
        total++;
        if (data_sram_rdata !== 32'h0000_0102) begin
            bad++;
            $display("FAIL timer_write_read got=%h exp=00000102", data_sram_rdata);
        end
        data_wr(32'hBFAF_F004, 32'h0000_0055, 4'b0001); tick();
        data_rd(32'hBFAF_F004); tick(); idle();
        total++;
        if (data_sram_rdata !== m_drdata) begin
            bad++;
            $display("FAIL timer_lane_write got=%h exp=%h", data_sram_rdata, m_drdata);
        end
    endtask

    function automatic logic [31:0] ram_va(input int unsigned idx);
        logic [31:0] seg;
        seg = ($urandom_range(0, 1) == 0) ? 32'h8000_0000 : 32'hA000_0000;
        return seg + idx * 4 + $urandom_range(0, 3);
    endfunction

    function automatic logic [31:0] mmio_va();
        logic [31:0] offs [4];
        offs[0] = 32'hF000; offs[1] = 32'hF004; offs[2] = 32'hF008; offs[3] = 32'hF00C;
        return 32'hBFAF_0000 + offs[$urandom_range(0, 3)] + $urandom_range(0, 3);
    endfunction

    task automatic test_random();
        int unsigned r;
        for (int unsigned i = 0; i < 16; i++) begin
            data_wr(32'h8000_0000 + i * 4, $urandom, 4'hF); tick();
        end
        idle();
        for (int cyc = 0; cyc < 400; cyc++) begin
            switch_in = 16'($urandom);
            inst_sram_en = ($urandom_range(0, 3) != 0);
            inst_sram_wen = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            inst_sram_wdata = $urandom;
            r = $urandom_range(0, 19);
            inst_sram_addr = (r == 0) ? $urandom : (r == 1) ? mmio_va() : ram_va($urandom_range(0, 15));
            data_sram_en = ($urandom_range(0, 3) != 0);
            data_sram_wen = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            data_sram_wdata = $urandom;
            r = $urandom_range(0, 9);
            data_sram_addr = (r == 0) ? $urandom : (r < 4) ? mmio_va() : ram_va($urandom_range(0, 15));
            tick();
            total++;
            if (inst_sram_rdata !== m_irdata) begin
                bad++;
                $display("FAIL rand_inst_rdata cyc=%0d got=%h exp=%h", cyc, inst_sram_rdata, m_irdata);
            end
            total++;
            if (data_sram_rdata !== m_drdata) begin
                bad++;
                $display("FAIL rand_data_rdata cyc=%0d got=%h exp=%h", cyc, data_sram_rdata, m_drdata);
            end
            total++;
            if (led_out !== m_led) begin
                bad++;
                $display("FAIL rand_led cyc=%0d got=%h exp=%h", cyc, led_out, m_led);
            end
            total++;
            if (err !== m_err || err_addr !== m_err_addr) begin
                bad++;
                $display("FAIL rand_err cyc=%0d got=%b/%h exp=%b/%h", cyc, err, err_addr, m_err, m_err_addr);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        data_wr(32'hBFAF_F000, 32'h0000_1234, 4'hF); tick();
        data_rd(32'h8000_0004); tick();
        inst_rd(32'h7000_0000); tick();
        data_rd(32'h8000_0008); inst_rd(32'h8000_000C);
        #2 rst = 0;
        #1;
        total++;
        if ({inst_sram_rdata, data_sram_rdata, led_out, err, err_addr} !== '0) begin
            bad++;
            $display("FAIL reset_async got irdata=%h drdata=%h led=%h err=%b err_addr=%h exp all zero",
                     inst_sram_rdata, data_sram_rdata, led_out, err, err_addr);
        end
        model_reset();
        idle();
        #1 rst = 1;
        repeat (5) tick();
        data_rd(32'hBFAF_F004); tick(); idle();
        total++;
        if (data_sram_rdata !== 32'd5) begin
            bad++;
            $display("FAIL timer_after_reset got=%h exp=00000005", data_sram_rdata);
        end
        data_rd(32'h8000_FFFC); inst_rd(32'h8000_0008); tick(); idle();
        total++;
        if (data_sram_rdata !== 32'h5A5A_1234 || inst_sram_rdata !== m_irdata) begin
            bad++;
            $display("FAIL ram_kept got d=%h i=%h exp d=5a5a1234 i=%h",
                     data_sram_rdata, inst_sram_rdata, m_irdata);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_byte_writes();
        test_conflict();
        test_boundary();
        test_mmio();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
